mul_spcl_stage: RTL

- Pipeline stage directly downstream of the multiplier classification logic.
- Consumes the operand classification flags and resolves special-case results: NaN, infinity, signed zero and invalid-operation.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the normal-path mantissa multiplier can be bypassed or back-pressured.
- Keeps a sticky invalid-operation (NV) flag for the FP status register.

---
 rtl/mul_spcl_stage_if.sv | 47 ++++
 rtl/mul_spcl_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mul_spcl_stage_if.sv
// -----------------------------------------------------------------------------
// mul_spcl_stage_if
// Handshake bundle for the multiplier special-case stage.
//   Upstream side : in_valid / in_ready plus the operand classification flags
//                   (a_sign, b_sign, a_is_n0, b_is_n0, r_isnan, is_inf_nan,
//                   status_nv).
//   Downstream side: out_valid / out_ready plus the resolved special result
//                   (out_bypass, out_result, out_nv).
// Modports:
//   master - the environment: drives the flags and out_ready.
//   slave  - the stage itself: consumes the flags, drives the results.
// -----------------------------------------------------------------------------
interface mul_spcl_stage_if #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
);
    localparam int RES_W = SIGN_W + EXPO_W + MANT_W;

    logic             in_valid;
    logic             in_ready;
    logic             a_sign;
    logic             b_sign;
    logic             a_is_n0;
    logic             b_is_n0;
    logic             r_isnan;
    logic             is_inf_nan;
    logic             status_nv;

    logic             out_valid;
    logic             out_ready;
    logic             out_bypass;
    logic [RES_W-1:0] out_result;
    logic             out_nv;

    modport master (
        output in_valid, a_sign, b_sign, a_is_n0, b_is_n0,
               r_isnan, is_inf_nan, status_nv, out_ready,
        input  in_ready, out_valid, out_bypass, out_result, out_nv
    );

    modport slave (
        input  in_valid, a_sign, b_sign, a_is_n0, b_is_n0,
               r_isnan, is_inf_nan, status_nv, out_ready,
        output in_ready, out_valid, out_bypass, out_result, out_nv
    );
endinterface

// File: rtl/mul_spcl_stage.sv
// -----------------------------------------------------------------------------
// mul_spcl_stage
// Pipeline stage behind the multiplier classification logic. Resolves the
// special-case result (canonical qNaN, signed infinity, signed zero) from the
// operand flags and registers it behind a valid/ready handshake with a
// 2-entry skid buffer (main register M drives the outputs, skid register S
// absorbs one extra entry). Also keeps a sticky invalid-operation flag.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   bus         - mul_spcl_stage_if.slave (flags in, special result out)
//   nv_sticky   - accumulated NV, set on an output transfer carrying NV
//   clr_sticky  - synchronous clear of nv_sticky (a same-cycle set wins)
// -----------------------------------------------------------------------------
module mul_spcl_stage #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    mul_spcl_stage_if.slave         bus,
    output logic                    nv_sticky,
    input  logic                    clr_sticky
);
    localparam int RES_W = SIGN_W + EXPO_W + MANT_W;

    typedef struct packed {
        logic             bypass;
        logic             nv;
        logic [RES_W-1:0] result;
    } entry_t;

    // Occupancy of the M/S pair. S is only ever full while M is full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    occ_e   state, state_nxt;
    entry_t m_q, s_q, in_entry;
    logic   load_m_in, load_m_skid, load_s;
    logic   r_sign;
    logic   out_fire;

    // ------------------------------------------------------------------
    // Special-case resolution, first match wins.
    // ------------------------------------------------------------------
    assign r_sign = bus.a_sign ^ bus.b_sign;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        in_entry        = '0;
        in_entry.nv     = bus.status_nv;
        if (bus.r_isnan) begin
            // Canonical quiet NaN: positive, mantissa MSB set.
            in_entry.bypass = 1'b1;
            in_entry.result = {{SIGN_W{1'b0}}, {EXPO_W{1'b1}},
                               1'b1, {(MANT_W-1){1'b0}}};
        end else if (bus.is_inf_nan) begin
            in_entry.bypass = 1'b1;
            in_entry.result = {r_sign, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (!bus.a_is_n0 || !bus.b_is_n0) begin
            in_entry.bypass = 1'b1;
            in_entry.result = {r_sign, {EXPO_W{1'b0}}, {MANT_W{1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its peers.
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (bus.in_valid) begin
                    load_m_in = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (bus.out_ready && bus.in_valid) begin
                    // M leaves and is replaced in the same cycle.
                    load_m_in = 1'b1;
                end else if (bus.out_ready) begin
                    state_nxt = ST_EMPTY;
                end else if (bus.in_valid) begin
                    load_s    = 1'b1;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so the input is ignored.
                if (bus.out_ready) begin
                    load_m_skid = 1'b1;
                    state_nxt   = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Both handshake outputs decode the state register directly.
    assign bus.in_ready  = (state != ST_FULL);
    assign bus.out_valid = (state != ST_EMPTY);
    assign out_fire      = bus.out_valid && bus.out_ready;

    // ------------------------------------------------------------------
    // Entry storage. M keeps its last contents when the stage drains, so
    // the outputs hold their last value while out_valid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: only two entries, and the outputs must read zero straight
        // out of reset, so the data registers are reset along with control.
        if (rst) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (load_m_in)        m_q <= in_entry;
            else if (load_m_skid) m_q <= s_q;
            if (load_s)           s_q <= in_entry;
        end
    end

    assign bus.out_bypass = m_q.bypass;
    assign bus.out_result = m_q.result;
    assign bus.out_nv     = m_q.nv;

    // ------------------------------------------------------------------
    // Sticky NV: a set in the same cycle as a clear takes priority.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       nv_sticky <= 1'b0;
        else if (out_fire && m_q.nv)   nv_sticky <= 1'b1;
        else if (clr_sticky)           nv_sticky <= 1'b0;
    end
endmodule
